sort_checker: RTL and testbench

- Hardware reader that scans a word array in the unified instruction/data memory after the multicycle CPU has written it.
- Reports whether the array is in ascending order, and if not, where the first violation is.
- Acts as a second initiator on the memory read port. It requests the port through a req/gnt handshake, so it can run once the CPU is halted or parked.
- Replaces bench-side direct memory peeking with a synthesizable self-check.

---
 rtl/cpu_pkg.sv | 18 +
 rtl/sort_checker_if.sv | 31 +++
 rtl/sort_checker_order_cmp.sv | 35 +++
 rtl/sort_checker.sv | 161 ++++++++++++++++
 tb/tb_sort_checker.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg
//   Shared definitions for the memory self-check hardware.
//   - chk_state_t : sort checker FSM states
//   - WORD_BYTES  : byte stride between consecutive array elements
//   - DATA_W      : memory word / address width
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN,
    FINISH
  } chk_state_t;

  localparam int WORD_BYTES = 4;
  localparam int DATA_W     = 32;

endpackage

// File: rtl/sort_checker_if.sv
// sort_checker_if
//   Read-port handshake between an initiator (the sort checker) and the
//   unified memory.
//   - mem_req   : initiator requests the read port
//   - mem_gnt   : port granted this cycle; the address is consumed when req && gnt
//   - mem_addr  : byte address
//   - mem_rdata : read data, valid one cycle after the consuming cycle
//   Modports: master (initiator side), slave (memory side).
interface sort_checker_if;
  import cpu_pkg::*;

  logic              mem_req;
  logic              mem_gnt;
  logic [DATA_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_gnt,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_gnt,
    output mem_rdata
  );

endinterface

// File: rtl/sort_checker_order_cmp.sv
// order_cmp
//   Combinational ordering check between two consecutive array elements.
//   Parameters:
//   - STRICT : 1 = equal neighbours are a violation, 0 = they are allowed
//   - SIGNED : 1 = two's-complement compare, 0 = unsigned compare
//   Ports:
//   - prev : element k-1
//   - cur  : element k
//   - viol : cur is out of order with respect to prev
module order_cmp
  import cpu_pkg::*;
#(
  parameter bit STRICT = 1'b1,
  parameter bit SIGNED = 1'b0
) (
  input  logic [DATA_W-1:0] prev,
  input  logic [DATA_W-1:0] cur,
  output logic              viol
);

  logic less;
  logic equal;

  always_comb begin
    less  = 1'b0;
    equal = (cur == prev);
    if (SIGNED) begin
      less = ($signed(cur) < $signed(prev));
    end else begin
      less = (cur < prev);
    end
    viol = STRICT ? (less || equal) : less;
  end

endmodule

// File: rtl/sort_checker.sv
// sort_checker
//   Scans a word array in the unified memory through a req/gnt read port
//   and reports whether it is in ascending order, plus the first element
//   that breaks the order.
//   Parameters: CNT_W (count/index width), STRICT, SIGNED (see order_cmp).
//   Ports:
//   - clk, rst        : clock, asynchronous active-low reset
//   - start           : begin a scan (only honoured when idle)
//   - base_addr       : byte address of element 0 (bits [1:0] ignored)
//   - count           : number of elements
//   - mem             : memory read port (master side)
//   - busy            : scan in progress
//   - done            : one-cycle pulse, results final
//   - pass            : array is ordered
//   - fail_index      : index of the second element of the first bad pair
//   - fail_value      : value at fail_index
module sort_checker
  import cpu_pkg::*;
#(
  parameter int CNT_W  = 16,
  parameter bit STRICT = 1'b1,
  parameter bit SIGNED = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  count,
  sort_checker_if.master    mem,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [CNT_W-1:0]  fail_index,
  output logic [DATA_W-1:0] fail_value
);

  chk_state_t        state;
  chk_state_t        state_next;

  logic [DATA_W-1:0] addr_r;
  logic [CNT_W-1:0]  issue_idx;
  logic [CNT_W-1:0]  ret_idx;
  logic [CNT_W-1:0]  last_idx;
  logic              inflight;
  logic              found;
  logic [DATA_W-1:0] prev;

  logic              accept;
  logic              grant;
  logic              last_issue;
  logic              check_en;
  logic              viol_raw;
  logic              viol;

  assign accept     = (state == IDLE) && start;
  assign grant      = (state == FETCH) && mem.mem_gnt;
  assign last_issue = (issue_idx == last_idx);

  // Element 0 only seeds prev; once a violation is recorded, the word that
  // may still be in flight is ignored.
  assign check_en = inflight && !found && (ret_idx != '0) &&
                    ((state == FETCH) || (state == DRAIN));
  assign viol     = check_en && viol_raw;

  order_cmp #(
    .STRICT(STRICT),
    .SIGNED(SIGNED)
  ) u_order_cmp (
    .prev(prev),
    .cur (mem.mem_rdata),
    .viol(viol_raw)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // A violation stops issuing at once; if a read was granted in the same
  // cycle, DRAIN absorbs its data before finishing.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_next = (count < CNT_W'(2)) ? FINISH : FETCH;
        end
      end
      FETCH: begin
        if (viol) begin
          state_next = grant ? DRAIN : FINISH;
        end else if (grant && last_issue) begin
          state_next = DRAIN;
        end
      end
      // DRAIN is only entered on a grant, so its single outstanding word
      // always returns during this cycle.
      DRAIN:   state_next = FINISH;
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    mem.mem_req = (state == FETCH);
    busy        = (state == FETCH) || (state == DRAIN);
    done        = (state == FINISH);
  end

  assign mem.mem_addr = addr_r;

  // Address counter, return tracking and result registers. Results are
  // cleared on an accepted start and otherwise hold between scans.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_r     <= '0;
      issue_idx  <= '0;
      ret_idx    <= '0;
      last_idx   <= '0;
      inflight   <= 1'b0;
      found      <= 1'b0;
      prev       <= '0;
      pass       <= 1'b0;
      fail_index <= '0;
      fail_value <= '0;
    end else begin
      inflight <= grant;
      if (accept) begin
        addr_r     <= base_addr & ~DATA_W'(WORD_BYTES - 1);
        issue_idx  <= '0;
        ret_idx    <= '0;
        last_idx   <= count - CNT_W'(1);
        found      <= 1'b0;
        pass       <= (count < CNT_W'(2));
        fail_index <= '0;
        fail_value <= '0;
      end else begin
        if (grant) begin
          addr_r    <= addr_r + DATA_W'(WORD_BYTES);
          issue_idx <= issue_idx + CNT_W'(1);
        end
        if (inflight) begin
          prev    <= mem.mem_rdata;
          ret_idx <= ret_idx + CNT_W'(1);
        end
        if (viol) begin
          found      <= 1'b1;
          fail_index <= ret_idx;
          fail_value <= mem.mem_rdata;
        end
        if ((state == DRAIN) && !found && !viol) begin
          pass <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sort_checker.sv
// tb_sort_checker
//   Directed bench for sort_checker. Three instances share one word memory:
//   u_dut (STRICT=1, unsigned), u_dut_ns (STRICT=0), u_dut_sg (SIGNED=1).
//   Each has its own read port with a one-cycle-latency memory response.
module tb_sort_checker;

  localparam int CNT_W = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic             start_a = 1'b0;
  logic             start_b = 1'b0;
  logic             start_c = 1'b0;
  logic [31:0]      base_addr = '0;
  logic [CNT_W-1:0] count = '0;

  logic             busy_a, done_a, pass_a;
  logic             busy_b, done_b, pass_b;
  logic             busy_c, done_c, pass_c;
  logic [CNT_W-1:0] fidx_a, fidx_b, fidx_c;
  logic [31:0]      fval_a, fval_b, fval_c;

  sort_checker_if bus_a ();
  sort_checker_if bus_b ();
  sort_checker_if bus_c ();

  sort_checker #(.CNT_W(CNT_W), .STRICT(1'b1), .SIGNED(1'b0)) u_dut (
    .clk(clk), .rst(rst), .start(start_a), .base_addr(base_addr), .count(count),
    .mem(bus_a), .busy(busy_a), .done(done_a), .pass(pass_a),
    .fail_index(fidx_a), .fail_value(fval_a)
  );

  sort_checker #(.CNT_W(CNT_W), .STRICT(1'b0), .SIGNED(1'b0)) u_dut_ns (
    .clk(clk), .rst(rst), .start(start_b), .base_addr(base_addr), .count(count),
    .mem(bus_b), .busy(busy_b), .done(done_b), .pass(pass_b),
    .fail_index(fidx_b), .fail_value(fval_b)
  );

  sort_checker #(.CNT_W(CNT_W), .STRICT(1'b1), .SIGNED(1'b1)) u_dut_sg (
    .clk(clk), .rst(rst), .start(start_c), .base_addr(base_addr), .count(count),
    .mem(bus_c), .busy(busy_c), .done(done_c), .pass(pass_c),
    .fail_index(fidx_c), .fail_value(fval_c)
  );

  // Word memory, indexed by byte address bits [9:2].
  logic [31:0] mem [0:255];

  // Grant pattern for u_dut: always granted, or 1,0,0 repeating.
  logic [1:0] ph = 2'd0;
  logic       gnt_mode = 1'b0;
  always @(posedge clk) ph <= (ph == 2'd2) ? 2'd0 : ph + 2'd1;
  assign bus_a.mem_gnt = gnt_mode ? (ph == 2'd0) : 1'b1;
  assign bus_b.mem_gnt = 1'b1;
  assign bus_c.mem_gnt = 1'b1;

  // Read data is only meaningful the cycle after a consumed address.
  always @(posedge clk)
    bus_a.mem_rdata <= (bus_a.mem_req && bus_a.mem_gnt) ? mem[bus_a.mem_addr[9:2]] : 32'hDEAD_BEEF;
  always @(posedge clk)
    bus_b.mem_rdata <= (bus_b.mem_req && bus_b.mem_gnt) ? mem[bus_b.mem_addr[9:2]] : 32'hDEAD_BEEF;
  always @(posedge clk)
    bus_c.mem_rdata <= (bus_c.mem_req && bus_c.mem_gnt) ? mem[bus_c.mem_addr[9:2]] : 32'hDEAD_BEEF;

  // Mid-cycle observation of u_dut's port: consumed addresses, request
  // cycles, address changes during stalls and done pulses.
  int          req_cnt = 0;
  int          stall_errs = 0;
  int          done_cnt = 0;
  logic [31:0] addr_log [$];
  logic        prev_req = 1'b0;
  logic        prev_gnt = 1'b0;
  logic [31:0] prev_addr = '0;

  always @(negedge clk) begin
    if (bus_a.mem_req) req_cnt++;
    if (bus_a.mem_req && bus_a.mem_gnt) addr_log.push_back(bus_a.mem_addr);
    if (prev_req && !prev_gnt && bus_a.mem_req && (bus_a.mem_addr != prev_addr)) stall_errs++;
    if (done_a) done_cnt++;
    prev_req  = bus_a.mem_req;
    prev_gnt  = bus_a.mem_gnt;
    prev_addr = bus_a.mem_addr;
  end

  // Observed-instance mux.
  int          sel = 0;
  logic        sel_done;
  logic        sel_pass;
  logic [15:0] sel_fidx;
  logic [31:0] sel_fval;
  always_comb begin
    sel_done = done_a; sel_pass = pass_a; sel_fidx = fidx_a; sel_fval = fval_a;
    if (sel == 1) begin
      sel_done = done_b; sel_pass = pass_b; sel_fidx = fidx_b; sel_fval = fval_b;
    end else if (sel == 2) begin
      sel_done = done_c; sel_pass = pass_c; sel_fidx = fidx_c; sel_fval = fval_c;
    end
  end

  int          num_checks = 0;
  int          num_fail = 0;
  logic [15:0] idx_c1;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    num_checks++;
    if (actual !== expected) begin
      num_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  task automatic drive_start(input int which, input logic val);
    if (which == 0) start_a = val;
    else if (which == 1) start_b = val;
    else start_c = val;
  endtask

  // Runs one scan on the chosen instance; done_cyc is the cycle (1 = the
  // cycle after start is sampled) in which done is seen, -1 on timeout.
  // restart_at > 0 pulses start again in that cycle.
  task automatic applyStimulus(input int which, input logic [31:0] base, input logic [15:0] cnt,
                               input int restart_at, output int done_cyc);
    int cyc;
    sel = which;
    addr_log.delete();
    req_cnt    = 0;
    stall_errs = 0;
    base_addr  = base;
    count      = cnt;
    drive_start(which, 1'b1);
    @(negedge clk);
    drive_start(which, 1'b0);
    cyc      = 1;
    done_cyc = -1;
    idx_c1   = sel_fidx;
    while (cyc < 300) begin
      if (sel_done) begin
        done_cyc = cyc;
        break;
      end
      if (cyc == restart_at) drive_start(which, 1'b1);
      @(negedge clk);
      drive_start(which, 1'b0);
      cyc++;
    end
    if (done_cyc < 0) checkOutput("done_timeout", 32'd0, 32'd1);
  endtask

  function automatic int logErrors(input logic [31:0] base, input int n);
    int errs = 0;
    for (int i = 0; i < addr_log.size(); i++)
      if (i >= n || addr_log[i] != base + 32'(4 * i)) errs++;
    return errs;
  endfunction

  int          dc;
  logic [31:0] max_addr;
  bit          reached;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[128] = 55;  mem[129] = 88;  mem[130] = 0;   mem[131] = 22;
    mem[132] = 77;  mem[133] = 11;  mem[134] = 99;  mem[135] = 33;
    mem[136] = 110; mem[137] = 66;  mem[138] = 121; mem[139] = 44;

    repeat (3) @(negedge clk);
    checkOutput("rst_busy", {31'd0, busy_a}, 32'd0);
    checkOutput("rst_done", {31'd0, done_a}, 32'd0);
    checkOutput("rst_pass", {31'd0, pass_a}, 32'd0);
    checkOutput("rst_req", {31'd0, bus_a.mem_req}, 32'd0);
    checkOutput("rst_addr", bus_a.mem_addr, 32'd0);
    checkOutput("rst_fidx", {16'd0, fidx_a}, 32'd0);
    checkOutput("rst_fval", fval_a, 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Unsorted: first break is 0 at index 2; the read of 524 is already granted.
    applyStimulus(0, 32'd512, 16'd12, 0, dc);
    checkOutput("uns_done_cyc", dc, 32'd6);
    checkOutput("uns_pass", {31'd0, sel_pass}, 32'd0);
    checkOutput("uns_fidx", {16'd0, sel_fidx}, 32'd2);
    checkOutput("uns_fval", sel_fval, 32'd0);
    checkOutput("uns_nreads", addr_log.size(), 32'd4);
    max_addr = '0;
    foreach (addr_log[i]) if (addr_log[i] > max_addr) max_addr = addr_log[i];
    checkOutput("uns_max_addr", max_addr, 32'd524);
    repeat (3) @(negedge clk);
    checkOutput("uns_hold_fidx", {16'd0, fidx_a}, 32'd2);

    // Sorted 0,11,...,121 with a stray start mid-scan that must be ignored.
    for (int i = 0; i < 12; i++) mem[128 + i] = 32'(11 * i);
    applyStimulus(0, 32'd512, 16'd12, 5, dc);
    checkOutput("srt_cleared_fidx", {16'd0, idx_c1}, 32'd0);
    checkOutput("srt_done_cyc", dc, 32'd14);
    checkOutput("srt_pass", {31'd0, sel_pass}, 32'd1);
    checkOutput("srt_nreads", addr_log.size(), 32'd12);
    checkOutput("srt_order", logErrors(32'd512, 12), 32'd0);
    repeat (2) @(negedge clk);

    // Duplicates 5,5,7; base with low bits set resolves to 768.
    mem[192] = 5; mem[193] = 5; mem[194] = 7;
    applyStimulus(0, 32'd770, 16'd3, 0, dc);
    checkOutput("dup_strict_done_cyc", dc, 32'd5);
    checkOutput("dup_strict_pass", {31'd0, sel_pass}, 32'd0);
    checkOutput("dup_strict_fidx", {16'd0, sel_fidx}, 32'd1);
    checkOutput("dup_strict_fval", sel_fval, 32'd5);
    checkOutput("dup_strict_addr0", addr_log.size() > 0 ? addr_log[0] : 32'hFFFF_FFFF, 32'd768);
    @(negedge clk);
    applyStimulus(1, 32'd768, 16'd3, 0, dc);
    checkOutput("dup_nonstrict_done_cyc", dc, 32'd5);
    checkOutput("dup_nonstrict_pass", {31'd0, sel_pass}, 32'd1);
    @(negedge clk);

    // Grant toggling 1,0,0 on a sorted scan.
    gnt_mode = 1'b1;
    applyStimulus(0, 32'd512, 16'd12, 0, dc);
    checkOutput("tog_pass", {31'd0, sel_pass}, 32'd1);
    checkOutput("tog_nreads", addr_log.size(), 32'd12);
    checkOutput("tog_order", logErrors(32'd512, 12), 32'd0);
    checkOutput("tog_stall_addr", stall_errs, 32'd0);
    checkOutput("tog_slower", (dc > 14) ? 32'd1 : 32'd0, 32'd1);
    gnt_mode = 1'b0;
    @(negedge clk);

    // count of 0 and 1: no memory access, immediate pass.
    for (int c = 0; c < 2; c++) begin
      applyStimulus(0, 32'd512, 16'(c), 0, dc);
      checkOutput($sformatf("cnt%0d_done_early", c), (dc >= 1 && dc <= 2) ? 32'd1 : 32'd0, 32'd1);
      checkOutput($sformatf("cnt%0d_pass", c), {31'd0, sel_pass}, 32'd1);
      checkOutput($sformatf("cnt%0d_reqs", c), req_cnt, 32'd0);
      @(negedge clk);
    end

    // -1,0,1: ordered when signed, broken at index 1 when unsigned.
    mem[225] = 32'hFFFF_FFFF; mem[226] = 32'd0; mem[227] = 32'd1;
    applyStimulus(2, 32'd900, 16'd3, 0, dc);
    checkOutput("sgn_done_cyc", dc, 32'd5);
    checkOutput("sgn_pass", {31'd0, sel_pass}, 32'd1);
    @(negedge clk);
    applyStimulus(0, 32'd900, 16'd3, 0, dc);
    checkOutput("uns_sgn_pass", {31'd0, sel_pass}, 32'd0);
    checkOutput("uns_sgn_fidx", {16'd0, sel_fidx}, 32'd1);
    checkOutput("uns_sgn_fval", sel_fval, 32'd0);
    @(negedge clk);

    // Address wrap-around from the top of the 32-bit space.
    mem[255] = 32'd10; mem[0] = 32'd20;
    applyStimulus(0, 32'hFFFF_FFFC, 16'd2, 0, dc);
    checkOutput("wrap_done_cyc", dc, 32'd4);
    checkOutput("wrap_pass", {31'd0, sel_pass}, 32'd1);
    checkOutput("wrap_nreads", addr_log.size(), 32'd2);
    checkOutput("wrap_addr1", addr_log.size() > 1 ? addr_log[1] : 32'hFFFF_FFFF, 32'd0);
    @(negedge clk);

    // Reset while element 5 is being requested.
    sel = 0;
    done_cnt  = 0;
    base_addr = 32'd512;
    count     = 16'd12;
    start_a   = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    reached = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (bus_a.mem_req && bus_a.mem_addr == 32'd532) begin
        reached = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checkOutput("rstmid_reached", {31'd0, reached}, 32'd1);
    #1 rst = 1'b0;
    #1;
    checkOutput("rstmid_req", {31'd0, bus_a.mem_req}, 32'd0);
    checkOutput("rstmid_busy", {31'd0, busy_a}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("rstmid_no_done", done_cnt, 32'd0);
    applyStimulus(0, 32'd512, 16'd12, 0, dc);
    checkOutput("rstmid_rerun_done_cyc", dc, 32'd14);
    checkOutput("rstmid_rerun_pass", {31'd0, sel_pass}, 32'd1);
    checkOutput("rstmid_rerun_order", logErrors(32'd512, 12), 32'd0);
    checkOutput("rstmid_rerun_nreads", addr_log.size(), 32'd12);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fail);
    $finish;
  end

endmodule
